// File: rtl/restore_division_pkg.sv
// Shared definitions for the restoring divider.
//   state_t        : controller state encoding (IDLE, LOAD_DVD, LOAD_DVR, ITER, DONE)
//   DEFAULT_WIDTH  : default operand/quotient/remainder width
package restore_division_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_DVD,
    LOAD_DVR,
    ITER,
    DONE
  } state_t;

endpackage

// File: rtl/restore_division_step.sv
// One restoring-division iteration, purely combinational.
//   a      : partial remainder, WIDTH+1 bits (always non-negative between iterations)
//   q      : dividend bits not yet consumed / quotient bits produced so far
//   m      : divisor
//   a_next : partial remainder after shift, trial subtract and optional restore
//   q_next : q shifted left with the new quotient bit in bit 0
module restore_division_step #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [2*WIDTH+1:0] aq_shifted;
  logic [WIDTH:0]     a_shifted;
  logic [WIDTH-1:0]   q_shifted;
  logic [WIDTH:0]     trial;
  logic               unused_msb;

  // Shift the {A,Q} pair left by one. A's top bit is only ever a sign
  // indicator of a failed trial, and a restored A is always below M, so the
  // bit shifted out of the top is always zero.
  assign aq_shifted = {a, q, 1'b0};
  assign unused_msb = aq_shifted[2*WIDTH+1];
  assign a_shifted  = aq_shifted[2*WIDTH:WIDTH];
  assign q_shifted  = aq_shifted[WIDTH-1:0];

  assign trial = a_shifted - {1'b0, m};

  always_comb begin
    if (trial[WIDTH]) begin
      // Trial went negative: keep the shifted remainder, quotient bit 0.
      a_next = a_shifted;
      q_next = q_shifted;
    end else begin
      a_next = trial;
      q_next = {q_shifted[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/restore_division.sv
// Sequential unsigned restoring divider with serial operand load.
// Optional feature macro: DIV_ZERO_DETECT_EN (adds dbz output and a
// short-circuit path for a zero divisor).
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : level request, sampled only in IDLE
//   data_in   : dividend on the first load cycle, divisor on the second
//   e         : done strobe, high for exactly one cycle
//   quotient  : result quotient, held until the next result
//   remainder : result remainder, held until the next result
//   dbz       : (DIV_ZERO_DETECT_EN only) divide-by-zero flag, high with e
module restore_division
  import restore_division_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             e,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic             dbz
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] q_step;
  logic             div_zero;

  restore_division_step #(.WIDTH(WIDTH)) u_step (
    .a      (a),
    .q      (q),
    .m      (m),
    .a_next (a_step),
    .q_next (q_step)
  );

`ifdef DIV_ZERO_DETECT_EN
  assign div_zero = (data_in == '0);
`else
  assign div_zero = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default before the
  // case statement; a path that leaves it unassigned would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = LOAD_DVD;
      LOAD_DVD: state_next = LOAD_DVR;
      LOAD_DVR: state_next = div_zero ? DONE : ITER;
      ITER:     if (count == CW'(1)) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a     <= '0;
      q     <= '0;
      m     <= '0;
      count <= '0;
    end else begin
      case (state)
        LOAD_DVD: q <= data_in;
        LOAD_DVR: begin
          m     <= data_in;
          a     <= '0;
          count <= CW'(WIDTH);
        end
        ITER: begin
          a     <= a_step;
          q     <= q_step;
          count <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded only on entry to DONE, held otherwise. On the
  // final iteration the result comes straight from the step logic so it is
  // valid in the same cycle as e.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e         <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      e <= (state_next == DONE);
      if (state_next == DONE) begin
        if (state == LOAD_DVR) begin
          // Zero-divisor short cut: same result the full iteration would give.
          quotient  <= '1;
          remainder <= q;
        end else begin
          quotient  <= q_step;
          remainder <= a_step[WIDTH-1:0];
        end
      end
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz <= 1'b0;
    end else begin
      dbz <= (state == LOAD_DVR) && (state_next == DONE);
    end
  end
`endif

endmodule

// File: tb/tb_restore_division.sv
// Self-checking bench for restore_division: directed cases, back-to-back
// operation, mid-operation reset and randomized operands, compared against
// plain integer division.
module tb_restore_division;
  import restore_division_pkg::*;

  localparam int W = DEFAULT_WIDTH;
  localparam int ALL_ONES = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         e;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
  logic         dbz;
`endif

  int tests = 0;
  int fails = 0;
  int prev_q = 0;
  int prev_r = 0;

  restore_division #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_in   (data_in),
    .e         (e),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_DETECT_EN
    ,
    .dbz       (dbz)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Runs one division starting from IDLE. keep leaves start high afterwards.
  task automatic do_op(input int dvd, input int dvr, input bit keep);
    int exp_q, exp_r, exp_lat, lat;
    if (dvr == 0) begin
      exp_q = ALL_ONES;
      exp_r = dvd;
    end else begin
      exp_q = dvd / dvr;
      exp_r = dvd % dvr;
    end
    exp_lat = W + 3;
`ifdef DIV_ZERO_DETECT_EN
    if (dvr == 0) exp_lat = 3;
`endif
    start   = 1'b1;
    data_in = W'(dvd);
    @(posedge clk); #1;               // edge 0: start sampled
    @(posedge clk); #1;               // edge 1: dividend captured
    check("hold_q_load", quotient, prev_q);
    check("hold_r_load", remainder, prev_r);
    data_in = W'(dvr);
    @(posedge clk); #1;               // edge 2: divisor captured
    data_in = W'($urandom);
    if (!keep) start = 1'b0;
    lat = 3;
    while (e !== 1'b1 && lat < 4 * W + 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency %0d/%0d", dvd, dvr), lat, exp_lat);
    check($sformatf("quotient %0d/%0d", dvd, dvr), quotient, exp_q);
    check($sformatf("remainder %0d/%0d", dvd, dvr), remainder, exp_r);
`ifdef DIV_ZERO_DETECT_EN
    check("dbz_on_done", dbz, (dvr == 0));
`endif
    prev_q = exp_q;
    prev_r = exp_r;
    @(posedge clk); #1;
    check("e_single_pulse", e, 1'b0);
    check("hold_q_after", quotient, prev_q);
    check("hold_r_after", remainder, prev_r);
`ifdef DIV_ZERO_DETECT_EN
    check("dbz_low_after", dbz, 1'b0);
`endif
  endtask

  initial begin
    bit seen_e;
    int dvd, dvr;

    #2;
    check("reset_e", e, 1'b0);
    check("reset_q", quotient, 0);
    check("reset_r", remainder, 0);
`ifdef DIV_ZERO_DETECT_EN
    check("reset_dbz", dbz, 1'b0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_op(3, 5, 1'b0);
    do_op(13, 4, 1'b0);
    do_op(31, 1, 1'b0);
    do_op(0, 7, 1'b0);
    do_op(9, 0, 1'b0);

    // Back-to-back with start held high across both operations.
    do_op(20, 6, 1'b1);
    do_op(17, 17, 1'b0);

    // Reset asserted while iterating.
    do_op(13, 4, 1'b0);
    start   = 1'b1;
    data_in = W'(22);
    @(posedge clk); #1;
    @(posedge clk); #1;
    data_in = W'(3);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset_e", e, 1'b0);
    check("midreset_q", quotient, 0);
    check("midreset_r", remainder, 0);
    @(negedge clk) rst_n = 1'b1;
    prev_q = 0;
    prev_r = 0;
    seen_e = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(posedge clk); #1;
      if (e === 1'b1) seen_e = 1'b1;
    end
    check("no_e_after_reset", seen_e, 1'b0);
    do_op(3, 5, 1'b0);

    // Randomized operands.
    for (int i = 0; i < 16; i++) begin
      dvd = int'($urandom_range(0, ALL_ONES));
      dvr = int'($urandom_range(0, ALL_ONES));
      do_op(dvd, dvr, ($urandom_range(0, 1) == 1));
    end
    start = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
